// File: rtl/spi_adc_scanner.sv
// rtl/spi_adc_scanner.sv - periodic MCP3008 scan sequencer feeding an SPI master
module spi_adc_scanner #(
    parameter int NUM_CH      = 8,
    parameter int SCAN_PERIOD = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        spi_busy,
    input  logic        spi_rx_data_tick,
    input  logic [23:0] spi_rx_data,
    output logic        spi_tx_data_tick,
    output logic [23:0] spi_tx_data,
    output logic        sample_tick,
    output logic [2:0]  sample_ch,
    output logic [9:0]  sample_data,
    output logic        scan_done,
    output logic        overrun,
    input  logic [2:0]  rd_ch,
    output logic [9:0]  rd_data
);
    localparam int            TW         = $clog2(SCAN_PERIOD);
    localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_PERIOD - 1);
    localparam logic [2:0]    CH_LAST    = 3'(NUM_CH - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, STORE} state_t;
    state_t state, state_next;

    logic [TW-1:0] timer;
    logic          scan_req;
    logic [2:0]    ch;
    logic [9:0]    rx_latch;
    logic [9:0]    result [0:7];
    logic          unused_rx_upper;

    assign unused_rx_upper = ^spi_rx_data[23:10];

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            timer <= '0;
        end else if (timer == TIMER_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // Registered so the request edge is one cycle ahead of the IDLE->ISSUE move.
    always_ff @(posedge clk) begin
        if (reset) begin
            scan_req <= 1'b0;
        end else begin
            scan_req <= enable && (timer == TIMER_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (scan_req && enable) state_next = ISSUE;
            ISSUE:   if (!spi_busy) state_next = WAIT;
            WAIT:    if (spi_rx_data_tick) state_next = STORE;
            STORE:   state_next = (ch == CH_LAST) ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ch               <= '0;
            rx_latch         <= '0;
            spi_tx_data_tick <= 1'b0;
            spi_tx_data      <= '0;
            sample_tick      <= 1'b0;
            sample_ch        <= '0;
            sample_data      <= '0;
            scan_done        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                result[i] <= '0;
            end
        end else begin
            spi_tx_data_tick <= 1'b0;
            sample_tick      <= 1'b0;
            scan_done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (state_next == ISSUE) ch <= '0;
                end
                ISSUE: begin
                    if (!spi_busy) begin
                        spi_tx_data_tick <= 1'b1;
                        spi_tx_data      <= {7'b0, 1'b1, 1'b1, ch, 12'b0};
                    end
                end
                WAIT: begin
                    if (spi_rx_data_tick) rx_latch <= spi_rx_data[9:0];
                end
                STORE: begin
                    result[ch]  <= rx_latch;
                    sample_tick <= 1'b1;
                    sample_ch   <= ch;
                    sample_data <= rx_latch;
                    scan_done   <= (ch == CH_LAST);
                    if (ch != CH_LAST) ch <= ch + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A request that finds the sequencer busy is dropped, not queued.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            overrun <= 1'b0;
        end else if (scan_req && state != IDLE) begin
            overrun <= 1'b1;
        end
    end

    assign rd_data = ({29'd0, rd_ch} < NUM_CH) ? result[rd_ch] : '0;

endmodule
